// File: rtl/rd_pointer_empty_1_tx_pkg.sv
// Shared FIFO package: default geometry used by both the read- and write-side pointer
// blocks, plus the Gray/binary pointer conversion helpers.
package rd_pointer_empty_1_tx_pkg;

    localparam int unsigned FIFO_DAT_W           = 8;
    localparam int unsigned FIFO_ALMOST_EMPTY_TH = 4;

    // Helpers operate on a fixed wide vector; callers zero-extend and truncate. Leading
    // zeros do not disturb either conversion, so any pointer up to this width works.
    localparam int unsigned PTR_MAX_W = 32;

    // Prefix-XOR from the MSB down: bin[i] = ^gray[MSB:i].
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] i_gray);
        logic [PTR_MAX_W-1:0] w_bin;
        w_bin[PTR_MAX_W-1] = i_gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ i_gray[i];
        end
        return w_bin;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/rd_pointer_empty_1_tx_if.sv
// Read-side FIFO pointer bus.
//   i_rd_en         : read request (reader -> block)
//   w_wrptr         : Gray write pointer from the write domain
//   o_rd_addr       : RAM read address
//   r_rdptr         : Gray read pointer returned to the writer
//   w_empty         : empty flag
//   w_allmost_empty : almost-empty flag
//   w_cnt           : occupancy in words
// master = reader/writer environment, slave = rd_pointer_empty_1_tx.
interface rd_pointer_empty_1_tx_if
    import rd_pointer_empty_1_tx_pkg::*;
#(
    parameter int unsigned DAT_W = FIFO_DAT_W
);
    logic             i_rd_en;
    logic [DAT_W:0]   w_wrptr;
    logic [DAT_W-1:0] o_rd_addr;
    logic [DAT_W:0]   r_rdptr;
    logic             w_empty;
    logic             w_allmost_empty;
    logic [DAT_W:0]   w_cnt;

    modport master (
        output i_rd_en, w_wrptr,
        input  o_rd_addr, r_rdptr, w_empty, w_allmost_empty, w_cnt
    );

    modport slave (
        input  i_rd_en, w_wrptr,
        output o_rd_addr, r_rdptr, w_empty, w_allmost_empty, w_cnt
    );
endinterface

// File: rtl/rd_pointer_empty_1_tx_ptr_sync.sv
// N-stage multi-bit flop synchronizer with asynchronous active-low reset.
//   i_clk  : destination clock
//   i_rstn : async active-low reset, clears every stage
//   i_d    : source-domain vector (must be Gray-coded so at most one bit moves)
//   o_q    : synchronized vector, STAGES edges after i_d
module ptr_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rd_pointer_empty_1_tx.sv
// Read-side pointer and empty/occupancy tracking for an async FIFO.
//   i_rd_clk  : read clock, the only clock in this block
//   i_rd_rstn : async active-low reset
//   bus       : slave side of rd_pointer_empty_1_tx_if (read request, incoming Gray
//               write pointer, RAM address, Gray read pointer, empty/almost-empty, count)
// Interface DAT_W must match this module's DAT_W.
module rd_pointer_empty_1_tx
    import rd_pointer_empty_1_tx_pkg::*;
#(
    parameter int unsigned DAT_W           = FIFO_DAT_W,
    parameter int unsigned ALMOST_EMPTY_TH = FIFO_ALMOST_EMPTY_TH,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                   i_rd_clk,
    input  logic                   i_rd_rstn,
    rd_pointer_empty_1_tx_if.slave bus
);

    localparam int unsigned PW = DAT_W + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_rdptr;
    logic [PW-1:0] r_cnt;
    logic          r_empty;
    logic          r_aempty;

    logic          w_rd_accept;
    logic [PW-1:0] w_next_bin;
    logic [PW-1:0] w_next_gray;
    logic [PW-1:0] w_sync_gray;
    logic [PW-1:0] w_sync_bin;
    logic [PW-1:0] w_occ;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wrptr_sync (
        .i_clk  (i_rd_clk),
        .i_rstn (i_rd_rstn),
        .i_d    (bus.w_wrptr),
        .o_q    (w_sync_gray)
    );

    // Flags are evaluated against the post-read pointer so a read is reflected in
    // empty/count at the same edge that advances the pointer, and the last word
    // read blocks any back-to-back read in the following cycle.
    always_comb begin
        w_rd_accept = bus.i_rd_en & ~r_empty;
        w_next_bin  = r_bin + {{DAT_W{1'b0}}, w_rd_accept};
        w_next_gray = PW'(bin2gray(PTR_MAX_W'(w_next_bin)));
        w_sync_bin  = PW'(gray2bin(PTR_MAX_W'(w_sync_gray)));
        w_occ       = w_sync_bin - w_next_bin;  // modulo 2**PW by width
    end

    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            r_bin    <= '0;
            r_rdptr  <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            r_bin    <= w_next_bin;
            r_rdptr  <= w_next_gray;
            r_cnt    <= w_occ;
            r_empty  <= (w_next_gray == w_sync_gray);
            r_aempty <= (w_occ <= PW'(ALMOST_EMPTY_TH));
        end
    end

    assign bus.o_rd_addr       = r_bin[DAT_W-1:0];
    assign bus.r_rdptr         = r_rdptr;
    assign bus.w_empty         = r_empty;
    assign bus.w_allmost_empty = r_aempty;
    assign bus.w_cnt           = r_cnt;

endmodule

// File: tb/tb_rd_pointer_empty_1_tx.sv
// Self-checking bench for rd_pointer_empty_1_tx (DAT_W=8, threshold 4, 2 sync stages).
module tb_rd_pointer_empty_1_tx;

    logic clk;
    logic rstn;

    rd_pointer_empty_1_tx_if #(.DAT_W(8)) bus ();

    rd_pointer_empty_1_tx #(
        .DAT_W           (8),
        .ALMOST_EMPTY_TH (4),
        .SYNC_STAGES     (2)
    ) u_dut (
        .i_rd_clk  (clk),
        .i_rd_rstn (rstn),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rd_m     = 0;
    int wr_m     = 0;

    logic [27:0] exp_q [$];
    logic [16:0] addr_q [$];
    logic [27:0] got;
    logic [27:0] e;

    function automatic logic [8:0] gray(input int n);
        logic [8:0] b;
        b = 9'(n);
        return b ^ (b >> 1);
    endfunction

    // Expected {empty, almost_empty, cnt, addr, rdptr} given read and visible write counts.
    function automatic logic [27:0] exp_state(input int rd, input int wr);
        logic [8:0] cnt;
        cnt = 9'(wr - rd);
        return {cnt == 9'd0, cnt <= 9'd4, cnt, 8'(rd), gray(rd)};
    endfunction

    function automatic logic [27:0] sample();
        return {bus.w_empty, bus.w_allmost_empty, bus.w_cnt, bus.o_rd_addr, bus.r_rdptr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int n);
        wr_m        = n;
        bus.w_wrptr = gray(n);
    endtask

    task automatic test_reset();
        rstn        = 1'b1;
        bus.i_rd_en = 1'b0;
        bus.w_wrptr = '0;
        #1 rstn = 1'b0;
        #2;
        exp_q.push_back(exp_state(0, 0));
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp %h", got, e);
        end
        tick();
        tick();
        rstn        = 1'b1;
        bus.i_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_state(0, 0));
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_rd_en_ignored cyc %0d: got %h exp %h", i, got, e);
            end
        end
        bus.i_rd_en = 1'b0;
    endtask

    task automatic test_sync_latency();
        set_wr(1);
        exp_q.push_back(exp_state(0, 0));
        exp_q.push_back(exp_state(0, 0));
        exp_q.push_back(exp_state(0, 1));
        for (int i = 1; i <= 3; i++) begin
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL sync_latency edge %0d: got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_threshold_drain();
        set_wr(6);
        exp_q.push_back(exp_state(0, 1));
        exp_q.push_back(exp_state(0, 1));
        exp_q.push_back(exp_state(0, 6));
        for (int i = 1; i <= 3; i++) begin
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL threshold_fill edge %0d: got %h exp %h", i, got, e);
            end
        end
        bus.i_rd_en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (rd_m < 6) rd_m++;
            exp_q.push_back(exp_state(rd_m, 6));
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL drain read %0d: got %h exp %h", i, got, e);
            end
        end
        bus.i_rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] last_addr;
        logic [8:0] last_ptr;
        logic [16:0] g17;
        logic [16:0] e17;
        bit         seen_wrap;
        seen_wrap   = 1'b0;
        last_addr   = 8'(rd_m);
        last_ptr    = gray(rd_m);
        bus.i_rd_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (wr_m < 300) begin
                set_wr(wr_m + 1);
                addr_q.push_back({8'(wr_m), gray(wr_m)});
            end
            tick();
            if (bus.o_rd_addr !== last_addr) begin
                g17 = {bus.o_rd_addr, bus.r_rdptr};
                e17 = (addr_q.size() > 0) ? addr_q.pop_front() : 17'h1ffff;
                n_checks++;
                if (g17 !== e17) begin
                    n_fail++;
                    $display("FAIL wrap_read: got %h exp %h", g17, e17);
                end
                n_checks++;
                if ($countones(bus.r_rdptr ^ last_ptr) != 1) begin
                    n_fail++;
                    $display("FAIL gray_one_bit_step: got %h exp one-bit change from %h",
                             bus.r_rdptr, last_ptr);
                end
                if (last_addr == 8'd255 && bus.o_rd_addr == 8'd0) seen_wrap = 1'b1;
                last_addr = bus.o_rd_addr;
                last_ptr  = bus.r_rdptr;
            end
            if (wr_m == 300 && addr_q.size() == 0 && bus.w_empty === 1'b1) break;
        end
        bus.i_rd_en = 1'b0;
        rd_m        = 300;
        n_checks++;
        if (addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain_timeout: got %0d pending exp 0", addr_q.size());
        end
        n_checks++;
        if (seen_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_addr_255_to_0: got %0b exp 1", seen_wrap);
        end
        n_checks++;
        if (bus.r_rdptr[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_rdptr_msb: got %0b exp 1", bus.r_rdptr[8]);
        end
        exp_q.push_back(exp_state(300, 300));
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL wrap_final: got %h exp %h", got, e);
        end
    endtask

    task automatic test_simultaneous();
        set_wr(303);
        exp_q.push_back(exp_state(300, 300));
        exp_q.push_back(exp_state(300, 300));
        exp_q.push_back(exp_state(300, 303));
        // Write step 304 reaches the sync output just as a read is issued.
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) begin
                set_wr(304);
                exp_q.push_back(exp_state(300, 303));
                exp_q.push_back(exp_state(300, 303));
            end
            if (i == 6) begin
                bus.i_rd_en = 1'b1;
                rd_m        = 301;
                exp_q.push_back(exp_state(301, 304));
            end
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL simultaneous step %0d: got %h exp %h", i, got, e);
            end
        end
        bus.i_rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        set_wr(313);
        exp_q.push_back(exp_state(301, 304));
        exp_q.push_back(exp_state(301, 304));
        exp_q.push_back(exp_state(301, 313));
        exp_q.push_back(exp_state(302, 313));
        exp_q.push_back(exp_state(303, 313));
        for (int i = 1; i <= 5; i++) begin
            if (i == 4) bus.i_rd_en = 1'b1;
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mid_drain_fill step %0d: got %h exp %h", i, got, e);
            end
        end
        // Now at cnt=10 with a read pending; reset must act before the next edge.
        #1;
        rstn = 1'b0;
        set_wr(0);
        rd_m = 0;
        #1;
        exp_q.push_back(exp_state(0, 0));
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_async_mid_drain: got %h exp %h", got, e);
        end
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_state(0, 0));
            tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL post_reset_no_accept cyc %0d: got %h exp %h", i, got, e);
            end
        end
        bus.i_rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_threshold_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_pointer_empty_1_tx.md
RD_POINTER_EMPTY_1_TX -- requirements
Module: rd_pointer_empty_1_tx

Interface
REQ-001 SHALL have parameter DAT_W, default 8, FIFO address width (depth 2**DAT_W).
REQ-002 SHALL have parameter ALMOST_EMPTY_TH, default 4, occupancy at or below which almost-empty asserts.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flop stages on the incoming write pointer.
REQ-004 SHALL have port i_rd_clk, input, 1, the single clock for all logic in this block.
REQ-005 SHALL have port i_rd_rstn, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port i_rd_en, input, 1, read request for one word this cycle.
REQ-007 SHALL have port w_wrptr, input, DAT_W+1, Gray-coded write pointer from the FIFO writer.
REQ-008 SHALL have port o_rd_addr, output, DAT_W, RAM read address.
REQ-009 SHALL have port r_rdptr, output, DAT_W+1, registered Gray-coded read pointer returned to the writer.
REQ-010 SHALL have port w_empty, output, 1, registered empty flag.
REQ-011 SHALL have port w_allmost_empty, output, 1, registered almost-empty flag.
REQ-012 SHALL have port w_cnt, output, DAT_W+1, registered occupancy in words, 0..2**DAT_W.

Function
REQ-013 SHALL accept a read (rd_accept) only when i_rd_en=1 and w_empty=0; i_rd_en while empty is ignored, with no pointer change.
REQ-014 SHALL hold a DAT_W+1-bit binary read pointer; next value = pointer + rd_accept, registered every i_rd_clk edge.
REQ-015 SHALL drive o_rd_addr from the low DAT_W bits of the registered binary pointer; 2**DAT_W-1 wraps to 0 and the MSB toggles.
REQ-016 SHALL register r_rdptr = next_bin XOR (next_bin >> 1), so r_rdptr changes by exactly one bit per accepted read.
REQ-017 SHALL pass w_wrptr through SYNC_STAGES flops before any use; no combinational path from w_wrptr to any output.
REQ-018 SHALL convert the synchronized Gray write pointer to binary with a prefix-XOR: bit i = XOR of bits DAT_W..i.
REQ-019 SHALL register w_empty <= (Gray of next_bin == synchronized w_wrptr).
REQ-020 SHALL register w_cnt <= (sync_wr_bin - next_bin) modulo 2**(DAT_W+1).
REQ-021 SHALL register w_allmost_empty <= (that occupancy <= ALMOST_EMPTY_TH), so it is 1 whenever w_empty is 1.
REQ-022 SHALL make a write pointer change visible on w_empty/w_cnt exactly SYNC_STAGES+1 i_rd_clk edges after w_wrptr changes, i.e. 3 at default.
REQ-023 SHALL make a read take effect on w_empty/w_cnt at the same edge it advances the pointer, i.e. 1 cycle.
REQ-024 SHALL handle a simultaneous read and synchronized-pointer advance in one cycle: count unchanged, no false empty.
REQ-025 SHALL on the final word (occupancy 1, rd_accept) assert w_empty at the next edge and block a back-to-back read in that cycle.

Reset
REQ-026 SHALL on i_rd_rstn=0 immediately clear the binary pointer, r_rdptr, o_rd_addr, w_cnt and all sync flops to 0.
REQ-027 SHALL on i_rd_rstn=0 set w_empty=1 and w_allmost_empty=1.
REQ-028 SHALL on reset mid-operation discard in-flight state; after deassertion, behave as from power-up with no spurious rd_accept.

Structure
REQ-029 SHALL take DAT_W and ALMOST_EMPTY_TH defaults from the shared FIFO package, also used by the write-side block.
REQ-030 SHALL place the gray-to-binary function in that package.
REQ-031 SHALL instantiate one sub-module, ptr_sync, a parameterized N-stage multi-bit flop synchronizer with async active-low reset.

Verification
REQ-032 SHALL test reset: after reset, w_empty=1, w_allmost_empty=1, w_cnt=0, o_rd_addr=0, r_rdptr=0; i_rd_en=1 for 5 cycles leaves all unchanged.
REQ-033 SHALL test sync latency: w_wrptr from Gray(0) to Gray(1) -> w_empty falls on the 3rd edge; w_cnt=1, w_allmost_empty=1.
REQ-034 SHALL test threshold and drain: w_wrptr=Gray(6) -> w_cnt=6, w_allmost_empty=0; 2 reads -> w_cnt=4, w_allmost_empty=1; 4 more reads -> w_empty=1, 7th read ignored.
REQ-035 SHALL test wrap: w_wrptr stepped to Gray(300) with continuous reads -> o_rd_addr wraps 255 to 0, r_rdptr MSB set, final w_empty=1, r_rdptr=Gray(300).
REQ-036 SHALL test simultaneous events: occupancy 3, one write step and one read in the same cycle -> w_cnt stays 3, w_empty stays 0.
REQ-037 SHALL test reset mid-drain: i_rd_rstn pulsed low at w_cnt=10 -> outputs return to reset values asynchronously, before the next clock edge.
